// File: rtl/procyon_types.sv
// procyon_types: shared LSU types, arbiter source enum and load/store decode
`ifndef LSU_ARB_STARVE_LIMIT
`define LSU_ARB_STARVE_LIMIT 4
`endif

package procyon_types;
  typedef logic [31:0] procyon_addr_t;
  typedef logic [31:0] procyon_data_t;
  typedef logic [5:0]  procyon_tag_t;

  typedef enum logic [2:0] {
    LSU_FUNC_LB,
    LSU_FUNC_LH,
    LSU_FUNC_LW,
    LSU_FUNC_LBU,
    LSU_FUNC_LHU,
    LSU_FUNC_SB,
    LSU_FUNC_SH,
    LSU_FUNC_SW
  } procyon_lsu_func_t;

  typedef enum logic [1:0] {
    SRC_RS,
    SRC_REPLAY,
    SRC_RETIRE
  } lsu_arb_src_t;

  function automatic logic lsu_func_is_store(input procyon_lsu_func_t f);
    return f inside {LSU_FUNC_SB, LSU_FUNC_SH, LSU_FUNC_SW};
  endfunction
endpackage

// File: rtl/lsu_arb.sv
// lsu_arb: picks one of retire/replay/RS per cycle for the LSU and registers the winner
module lsu_arb
  import procyon_types::*;
#(
  parameter int STARVE_LIMIT = `LSU_ARB_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_lq_full,
  input  logic              i_sq_full,
  input  logic              i_rs_valid,
  input  procyon_lsu_func_t i_rs_lsu_func,
  input  procyon_addr_t     i_rs_addr,
  input  procyon_data_t     i_rs_data,
  input  procyon_tag_t      i_rs_tag,
  output logic              o_rs_stall,
  input  logic              i_replay_valid,
  input  procyon_lsu_func_t i_replay_lsu_func,
  input  procyon_addr_t     i_replay_addr,
  input  procyon_tag_t      i_replay_tag,
  output logic              o_replay_ack,
  input  logic              i_sq_retire_valid,
  input  procyon_lsu_func_t i_sq_retire_lsu_func,
  input  procyon_addr_t     i_sq_retire_addr,
  input  procyon_data_t     i_sq_retire_data,
  input  procyon_tag_t      i_sq_retire_tag,
  output logic              o_sq_retire_ack,
  output logic              o_lq_alloc_en,
  output logic              o_sq_alloc_en,
  output logic              o_valid,
  output procyon_lsu_func_t o_lsu_func,
  output procyon_addr_t     o_addr,
  output procyon_data_t     o_data,
  output procyon_tag_t      o_tag,
  output lsu_arb_src_t      o_src
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0]     starve_cnt;
  logic              advance;
  logic              rs_store;
  logic              rs_elig;
  logic              rs_first;
  logic              grant_retire;
  logic              grant_replay;
  logic              grant_rs;
  logic              grant_any;
  lsu_arb_src_t      win_src;
  procyon_lsu_func_t win_func;
  procyon_addr_t     win_addr;
  procyon_data_t     win_data;
  procyon_tag_t      win_tag;

  // Gating advance with n_rst keeps every grant, ack and alloc low during reset.
  assign advance      = n_rst & (~o_valid | ~i_stall);
  assign rs_store     = lsu_func_is_store(i_rs_lsu_func);
  assign rs_elig      = i_rs_valid & (rs_store ? ~i_sq_full : ~i_lq_full);
  assign rs_first     = rs_elig & (starve_cnt == CW'(STARVE_LIMIT));
  assign grant_retire = advance & i_sq_retire_valid;
  assign grant_replay = advance & ~i_flush & ~i_sq_retire_valid & i_replay_valid & ~rs_first;
  assign grant_rs     = advance & ~i_flush & ~i_sq_retire_valid & rs_elig & ~grant_replay;
  assign grant_any    = grant_retire | grant_replay | grant_rs;

  assign o_rs_stall      = ~grant_rs;
  assign o_replay_ack    = grant_replay;
  assign o_sq_retire_ack = grant_retire;
  assign o_lq_alloc_en   = grant_rs & ~rs_store;
  assign o_sq_alloc_en   = grant_rs & rs_store;

  assign win_src  = grant_retire ? SRC_RETIRE : grant_replay ? SRC_REPLAY : SRC_RS;
  assign win_func = grant_retire ? i_sq_retire_lsu_func : grant_replay ? i_replay_lsu_func : i_rs_lsu_func;
  assign win_addr = grant_retire ? i_sq_retire_addr : grant_replay ? i_replay_addr : i_rs_addr;
  assign win_data = grant_retire ? i_sq_retire_data : grant_replay ? '0 : i_rs_data;
  assign win_tag  = grant_retire ? i_sq_retire_tag : grant_replay ? i_replay_tag : i_rs_tag;

  // Count cycles an eligible RS op loses; saturates at the limit where RS outranks replay.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) starve_cnt <= '0;
    else if (i_flush | ~rs_elig | grant_rs) starve_cnt <= '0;
    else if (advance & (starve_cnt != CW'(STARVE_LIMIT))) starve_cnt <= starve_cnt + 1'b1;
  end

  // Output register: load winner on advance, hold under stall, drop non-retire entries on flush.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_valid    <= 1'b0;
      o_src      <= SRC_RS;
      o_lsu_func <= LSU_FUNC_LB;
      o_addr     <= '0;
      o_data     <= '0;
      o_tag      <= '0;
    end else if (advance) begin
      o_valid <= grant_any;
      if (grant_any) begin
        o_src      <= win_src;
        o_lsu_func <= win_func;
        o_addr     <= win_addr;
        o_data     <= win_data;
        o_tag      <= win_tag;
      end
    end else if (i_flush && o_src != SRC_RETIRE) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed and randomized checks of lsu_arb against a cycle-level reference model
module tb_lsu_arb;
  import procyon_types::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic flush, stall, lq_full, sq_full;
  logic rs_v, rep_v, ret_v;
  procyon_lsu_func_t rs_func, rep_func, ret_func;
  procyon_addr_t rs_addr, rep_addr, ret_addr;
  procyon_data_t rs_data, ret_data;
  procyon_tag_t rs_tag, rep_tag, ret_tag;

  logic o_rs_stall, o_replay_ack, o_sq_retire_ack, o_lq_alloc_en, o_sq_alloc_en, o_valid;
  procyon_lsu_func_t o_lsu_func;
  procyon_addr_t o_addr;
  procyon_data_t o_data;
  procyon_tag_t o_tag;
  lsu_arb_src_t o_src;

  logic m_valid;
  lsu_arb_src_t m_src;
  procyon_lsu_func_t m_func;
  procyon_addr_t m_addr;
  procyon_data_t m_data;
  procyon_tag_t m_tag;
  int m_starve;

  int checks = 0;
  int errors = 0;
  logic obs_rs_grant;

  lsu_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .n_rst(n_rst), .i_flush(flush), .i_stall(stall),
    .i_lq_full(lq_full), .i_sq_full(sq_full),
    .i_rs_valid(rs_v), .i_rs_lsu_func(rs_func), .i_rs_addr(rs_addr), .i_rs_data(rs_data),
    .i_rs_tag(rs_tag), .o_rs_stall(o_rs_stall),
    .i_replay_valid(rep_v), .i_replay_lsu_func(rep_func), .i_replay_addr(rep_addr),
    .i_replay_tag(rep_tag), .o_replay_ack(o_replay_ack),
    .i_sq_retire_valid(ret_v), .i_sq_retire_lsu_func(ret_func), .i_sq_retire_addr(ret_addr),
    .i_sq_retire_data(ret_data), .i_sq_retire_tag(ret_tag), .o_sq_retire_ack(o_sq_retire_ack),
    .o_lq_alloc_en(o_lq_alloc_en), .o_sq_alloc_en(o_sq_alloc_en),
    .o_valid(o_valid), .o_lsu_func(o_lsu_func), .o_addr(o_addr), .o_data(o_data),
    .o_tag(o_tag), .o_src(o_src)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_st(input procyon_lsu_func_t f);
    return f == LSU_FUNC_SB || f == LSU_FUNC_SH || f == LSU_FUNC_SW;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_src = SRC_RS;
    m_func = LSU_FUNC_LB;
    m_addr = '0;
    m_data = '0;
    m_tag = '0;
    m_starve = 0;
  endtask

  task automatic clr();
    {flush, stall, lq_full, sq_full, rs_v, rep_v, ret_v} = '0;
    rs_func = LSU_FUNC_LW; rep_func = LSU_FUNC_LW; ret_func = LSU_FUNC_SW;
    rs_addr = '0; rep_addr = '0; ret_addr = '0;
    rs_data = '0; ret_data = '0;
    rs_tag = '0; rep_tag = '0; ret_tag = '0;
  endtask

  // One clock: check grant outputs before the edge, update the model, check the register after.
  task automatic cycle();
    logic adv, el;
    int win;
    #1;
    adv = !m_valid || !stall;
    el = rs_v && (is_st(rs_func) ? !sq_full : !lq_full);
    win = -1;
    if (adv && ret_v) win = 2;
    else if (adv && !flush) begin
      if (rep_v && !(el && m_starve == LIMIT)) win = 1;
      else if (el) win = 0;
    end
    obs_rs_grant = !o_rs_stall;
    check("rs_stall", o_rs_stall, win != 0);
    check("replay_ack", o_replay_ack, win == 1);
    check("retire_ack", o_sq_retire_ack, win == 2);
    check("lq_alloc", o_lq_alloc_en, win == 0 && !is_st(rs_func));
    check("sq_alloc", o_sq_alloc_en, win == 0 && is_st(rs_func));
    check("starve_cnt", dut.starve_cnt, m_starve);
    @(posedge clk);
    #1;
    if (flush || !el || win == 0) m_starve = 0;
    else if (adv && m_starve < LIMIT) m_starve++;
    if (adv) begin
      m_valid = win >= 0;
      if (win == 2) begin
        m_src = SRC_RETIRE; m_func = ret_func; m_addr = ret_addr; m_data = ret_data; m_tag = ret_tag;
      end else if (win == 1) begin
        m_src = SRC_REPLAY; m_func = rep_func; m_addr = rep_addr; m_data = '0; m_tag = rep_tag;
      end else if (win == 0) begin
        m_src = SRC_RS; m_func = rs_func; m_addr = rs_addr; m_data = rs_data; m_tag = rs_tag;
      end
    end else if (flush && m_src != SRC_RETIRE) m_valid = 1'b0;
    check("o_valid", o_valid, m_valid);
    if (m_valid) begin
      check("o_src", o_src, m_src);
      check("o_lsu_func", o_lsu_func, m_func);
      check("o_addr", o_addr, m_addr);
      check("o_data", o_data, m_data);
      check("o_tag", o_tag, m_tag);
    end
    @(negedge clk);
  endtask

  initial begin
    clr();
    model_reset();
    n_rst = 1'b0;
    rs_v = 1'b1; rep_v = 1'b1; ret_v = 1'b1;
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_src", o_src, SRC_RS);
    check("rst_addr", o_addr, 0);
    check("rst_rs_stall", o_rs_stall, 1);
    check("rst_acks", {o_replay_ack, o_sq_retire_ack, o_lq_alloc_en, o_sq_alloc_en}, 0);
    @(posedge clk);
    #1;
    check("rst_valid_edge", o_valid, 0);
    @(negedge clk);
    n_rst = 1'b1;
    clr();

    rs_v = 1'b1; rs_func = LSU_FUNC_LW; rs_addr = 32'h100; rs_tag = 6'd3;
    cycle();
    check("t018_valid", o_valid, 1);
    check("t018_addr", o_addr, 32'h100);
    check("t018_src", o_src, SRC_RS);

    ret_v = 1'b1; ret_func = LSU_FUNC_SW; ret_addr = 32'h200; ret_data = 32'hdead;
    rep_v = 1'b1; rep_addr = 32'h180;
    cycle();
    check("t019_src", o_src, SRC_RETIRE);
    check("t019_addr", o_addr, 32'h200);

    clr();
    cycle();
    rep_v = 1'b1; rep_addr = 32'h500; rs_v = 1'b1; rs_func = LSU_FUNC_LW; rs_addr = 32'h600;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      check("t020_rs_grant", obs_rs_grant, i == 5);
    end
    check("t020_starve_zero", dut.starve_cnt, 0);

    clr();
    rs_v = 1'b1; rs_func = LSU_FUNC_LW; lq_full = 1'b1;
    cycle();
    check("t021_lw_blocked", obs_rs_grant, 0);
    rs_func = LSU_FUNC_SB;
    cycle();
    check("t021_sb_granted", obs_rs_grant, 1);

    clr();
    rep_v = 1'b1; rep_addr = 32'h300; rep_tag = 6'd9;
    cycle();
    stall = 1'b1;
    repeat (3) cycle();
    check("t022_held_src", o_src, SRC_REPLAY);
    check("t022_held_addr", o_addr, 32'h300);
    flush = 1'b1;
    cycle();
    check("t022_flushed", o_valid, 0);

    clr();
    ret_v = 1'b1; ret_addr = 32'h400; ret_data = 32'h1234;
    cycle();
    clr();
    stall = 1'b1; flush = 1'b1;
    cycle();
    check("t023_kept_valid", o_valid, 1);
    check("t023_kept_src", o_src, SRC_RETIRE);
    flush = 1'b0;
    cycle();
    #2 n_rst = 1'b0;
    #1;
    check("t023_async_rst", o_valid, 0);
    model_reset();
    #1 n_rst = 1'b1;
    @(negedge clk);
    clr();

    repeat (3000) begin
      stall = $urandom_range(0, 9) < 3;
      flush = $urandom_range(0, 19) == 0;
      lq_full = $urandom_range(0, 9) < 3;
      sq_full = $urandom_range(0, 9) < 3;
      rs_v = $urandom_range(0, 9) < 7;
      rep_v = $urandom_range(0, 9) < 7;
      ret_v = $urandom_range(0, 9) < 2;
      rs_func = procyon_lsu_func_t'($urandom_range(0, 7));
      rep_func = procyon_lsu_func_t'($urandom_range(0, 4));
      ret_func = procyon_lsu_func_t'($urandom_range(5, 7));
      rs_addr = $urandom; rep_addr = $urandom; ret_addr = $urandom;
      rs_data = $urandom; ret_data = $urandom;
      rs_tag = procyon_tag_t'($urandom); rep_tag = procyon_tag_t'($urandom);
      ret_tag = procyon_tag_t'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_arb.md
LSU_ARB -- requirements
Module: lsu_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default `LSU_ARB_STARVE_LIMIT (4): number of lost cycles before RS outranks replay.
REQ-002 SHALL have ports (name dir width meaning):
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- i_flush  in  1  pipeline flush
- i_stall  in  1  downstream LSU stage cannot accept
- i_lq_full  in  1  LQ full
- i_sq_full  in  1  SQ full
- i_rs_valid  in  1  RS op request
- i_rs_lsu_func  in  procyon_lsu_func_t  RS op type
- i_rs_addr  in  procyon_addr_t  RS op address
- i_rs_data  in  procyon_data_t  RS store data
- i_rs_tag  in  procyon_tag_t  RS op ROB tag
- o_rs_stall  out  1  RS op not accepted this cycle
- i_replay_valid  in  1  load replay request
- i_replay_lsu_func  in  procyon_lsu_func_t  replay type
- i_replay_addr  in  procyon_addr_t  replay address
- i_replay_tag  in  procyon_tag_t  replay tag
- o_replay_ack  out  1  replay accepted
- i_sq_retire_valid  in  1  retiring store request
- i_sq_retire_lsu_func  in  procyon_lsu_func_t  store type
- i_sq_retire_addr  in  procyon_addr_t  store address
- i_sq_retire_data  in  procyon_data_t  store data
- i_sq_retire_tag  in  procyon_tag_t  store tag
- o_sq_retire_ack  out  1  retire accepted
- o_lq_alloc_en  out  1  allocate LQ entry (RS load granted)
- o_sq_alloc_en  out  1  allocate SQ entry (RS store granted)
- o_valid, o_lsu_func, o_addr, o_data, o_tag  out  1/func/addr/data/tag  registered winner
- o_src  out  lsu_arb_src_t  winner source (SRC_RS, SRC_REPLAY, SRC_RETIRE)

Function
REQ-003 SHALL compute advance = ~o_valid | ~i_stall; no grant, ack or alloc when advance=0.
REQ-004 SHALL treat RS request eligible only if i_rs_valid and (load: ~i_lq_full; store: ~i_sq_full).
REQ-005 SHALL grant at most one source per cycle, priority retire > replay > RS; when starve_cnt == STARVE_LIMIT, RS (if eligible) SHALL beat replay but never retire.
REQ-006 SHALL assert o_sq_retire_ack / o_replay_ack combinationally in the grant cycle; o_rs_stall = ~(RS granted).
REQ-007 SHALL assert o_lq_alloc_en (RS load) or o_sq_alloc_en (RS store) in the RS grant cycle only; never for replay or retire.
REQ-008 SHALL load winner fields into output register on the clock edge after grant (latency 1); advance with no grant clears o_valid.
REQ-009 SHALL hold output register unchanged while o_valid & i_stall.
REQ-010 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each advance cycle RS is eligible but not granted; reset to 0 on RS grant or when RS not eligible.
REQ-011 During i_flush SHALL grant only retire; RS and replay not acked, no alloc, starve_cnt cleared.
REQ-012 On i_flush SHALL clear o_valid next cycle unless register holds SRC_RETIRE (committed store survives flush); a retire granted in the flush cycle SHALL be registered.
REQ-013 Simultaneous i_flush and i_stall: non-retire entry SHALL still be cleared.

Reset
REQ-014 On n_rst low SHALL set o_valid=0, starve_cnt=0, o_src=SRC_RS; payload fields 0.
REQ-015 Combinational outputs SHALL be 0 (o_rs_stall=1) while in reset since no grant occurs.

Structure
REQ-016 lsu_arb_src_t enum SHALL live in procyon_types; `LSU_ARB_STARVE_LIMIT in common.svh; load/store decode of procyon_lsu_func_t SHALL be a package function.
REQ-017 No sub-module; single module with grant logic, starvation counter, output register.

Verification
REQ-018 RS LW addr 0x100 tag 3 alone -> o_lq_alloc_en=1 same cycle; next cycle o_valid=1, o_addr=0x100, o_src=SRC_RS.
REQ-019 Retire SW 0x200 + replay + RS same cycle -> only o_sq_retire_ack; o_src=SRC_RETIRE; RS stall=1.
REQ-020 Replay held valid, RS LW valid continuously, STARVE_LIMIT=4 -> RS granted on 5th cycle, starve_cnt back to 0.
REQ-021 RS LW with i_lq_full=1 -> o_rs_stall=1, no alloc, starve_cnt stays 0; RS SB granted when i_sq_full=0.
REQ-022 o_valid=1 SRC_REPLAY, i_stall=1 3 cycles -> output held, no acks; then i_flush -> o_valid=0 next cycle.
REQ-023 Output holds SRC_RETIRE, i_flush=1 -> entry retained; n_rst pulse mid-stall -> o_valid=0 immediately.
